// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - MIPS PC register with 5-source priority select and stall-time pending redirect
// Optional feature macro PC_ALIGN_CHECK_EN: misaligned redirect targets trap to EXC_VECTOR.
module pc_next_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
  parameter int unsigned      INC          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             exc,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic             redirect_pending,
  output logic             misalign
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       pend_pri_q, pend_pri_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [2:0]       cur_pri;
  logic [WIDTH-1:0] cur_target;

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign pc               = pc_q;
  assign pc_plus_inc      = pc_q + WIDTH'(INC);
  assign redirect_pending = pend_valid_q;

  always_comb begin
    cur_pri    = 3'd0;
    cur_target = '0;
    if (exc) begin
      cur_pri    = 3'd4;
      cur_target = EXC_VECTOR;
    end else if (jr) begin
      cur_pri    = 3'd3;
      cur_target = jr_target;
    end else if (jump) begin
      cur_pri    = 3'd2;
      cur_target = jump_target;
    end else if (branch_taken) begin
      cur_pri    = 3'd1;
      cur_target = branch_target;
    end
  end

  always_comb begin
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pri_d   = pend_pri_q;
    pend_tgt_d   = pend_tgt_q;
`ifdef PC_ALIGN_CHECK_EN
    misalign_d   = 1'b0;
`endif
    if (cur_pri == 3'd4) begin
      // Exceptions bypass the stall and flush any held redirect.
      pc_d         = EXC_VECTOR;
      pend_valid_d = 1'b0;
    end else if (stall) begin
      if (cur_pri != 3'd0 && (!pend_valid_q || cur_pri > {1'b0, pend_pri_q})) begin
        pend_valid_d = 1'b1;
        pend_pri_d   = cur_pri[1:0];
        pend_tgt_d   = cur_target;
      end
    end else begin
      pc_d = pc_plus_inc;
      if (pend_valid_q && cur_pri <= {1'b0, pend_pri_q}) begin
        pc_d = pend_tgt_q;
      end else if (cur_pri != 3'd0) begin
        pc_d = cur_target;
      end
      pend_valid_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      if ((pend_valid_q || cur_pri != 3'd0) && pc_d[1:0] != 2'b00) begin
        pc_d       = EXC_VECTOR;
        misalign_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      pend_valid_q <= 1'b0;
      pend_pri_q   <= 2'd0;
      pend_tgt_q   <= '0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pri_q   <= pend_pri_d;
      pend_tgt_q   <= pend_tgt_d;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - self-checking bench for pc_next_unit with a behavioural next-PC model
module tb_pc_next_unit;
  localparam int W = 32;
  localparam logic [W-1:0] EXC = 32'h0000_0180;

  logic         clk = 1'b0;
  logic         reset, stall, exc, jr, jump, branch_taken;
  logic [W-1:0] jr_target, jump_target, branch_target;
  logic [W-1:0] pc, pc_plus_inc;
  logic         redirect_pending, misalign;

  int n_pass = 0;
  int n_total = 0;

  logic [W-1:0] m_pc;
  bit           m_pv;
  int           m_pp;
  logic [W-1:0] m_pt;
  bit           m_mis;

  pc_next_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .exc(exc),
    .jr(jr), .jr_target(jr_target), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .pc_plus_inc(pc_plus_inc),
    .redirect_pending(redirect_pending), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic idle();
    reset = 0; stall = 0; exc = 0; jr = 0; jump = 0; branch_taken = 0;
    jr_target = '0; jump_target = '0; branch_target = '0;
  endtask

  // Reference: apply the priority / pending rules to the current inputs.
  task automatic model_step();
    int           cp;
    logic [W-1:0] ct, nxt;
    bit           redir;
    m_mis = 0;
    if (reset) begin
      m_pc = '0; m_pv = 0; m_pp = 0; m_pt = '0;
      return;
    end
    cp = exc ? 4 : jr ? 3 : jump ? 2 : branch_taken ? 1 : 0;
    ct = exc ? EXC : jr ? jr_target : jump ? jump_target : branch_target;
    if (cp == 4) begin
      m_pc = EXC; m_pv = 0;
    end else if (stall) begin
      if (cp > 0 && (!m_pv || cp > m_pp)) begin
        m_pv = 1; m_pp = cp; m_pt = ct;
      end
    end else begin
      redir = 1;
      if (m_pv && cp <= m_pp) nxt = m_pt;
      else if (cp > 0)       nxt = ct;
      else begin nxt = m_pc + 4; redir = 0; end
      m_pv = 0;
`ifdef PC_ALIGN_CHECK_EN
      if (redir && (nxt % 4) != 0) begin nxt = EXC; m_mis = 1; end
`endif
      m_pc = nxt;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1; stall = 1; branch_taken = 1; branch_target = 32'h44;
    step(); step();
    idle();
    n_total++; if (pc !== 32'h0) $display("FAIL reset_pc got %h want %h", pc, 32'h0); else n_pass++;
    n_total++; if (redirect_pending !== 1'b0) $display("FAIL reset_pending got %b want 0", redirect_pending); else n_pass++;
    n_total++; if (pc_plus_inc !== 32'h4) $display("FAIL reset_pc_plus_inc got %h want %h", pc_plus_inc, 32'h4); else n_pass++;
    n_total++; if (misalign !== 1'b0) $display("FAIL reset_misalign got %b want 0", misalign); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [W-1:0] exp;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = W'(i * 4);
      n_total++; if (pc !== exp) $display("FAIL seq_pc%0d got %h want %h", i, pc, exp); else n_pass++;
    end
    n_total++; if (redirect_pending !== 1'b0) $display("FAIL seq_pending got %b want 0", redirect_pending); else n_pass++;
  endtask

  task automatic test_priority();
    jump = 1; jump_target = 32'h400; branch_taken = 1; branch_target = 32'h200;
    step(); idle();
    n_total++; if (pc !== 32'h400) $display("FAIL prio_jump_over_branch got %h want %h", pc, 32'h400); else n_pass++;
  endtask

  task automatic test_stall_pending();
    stall = 1; branch_taken = 1; branch_target = 32'h80;
    step();
    n_total++; if (pc !== 32'h400 || redirect_pending !== 1'b1)
      $display("FAIL stall_c1 got pc=%h pend=%b want pc=%h pend=1", pc, redirect_pending, 32'h400); else n_pass++;
    branch_taken = 0; jr = 1; jr_target = 32'h900;
    step();
    jr = 0;
    step();
    n_total++; if (pc !== 32'h400 || redirect_pending !== 1'b1)
      $display("FAIL stall_c3 got pc=%h pend=%b want pc=%h pend=1", pc, redirect_pending, 32'h400); else n_pass++;
    stall = 0;
    step();
    n_total++; if (pc !== 32'h900 || redirect_pending !== 1'b0)
      $display("FAIL stall_release got pc=%h pend=%b want pc=%h pend=0", pc, redirect_pending, 32'h900); else n_pass++;
    step();
    n_total++; if (pc !== 32'h904) $display("FAIL stall_after got %h want %h", pc, 32'h904); else n_pass++;
  endtask

  task automatic test_exc_during_stall();
    stall = 1; branch_taken = 1; branch_target = 32'h80;
    step();
    branch_taken = 0; exc = 1;
    step(); idle();
    n_total++; if (pc !== EXC || redirect_pending !== 1'b0)
      $display("FAIL exc_stall got pc=%h pend=%b want pc=%h pend=0", pc, redirect_pending, EXC); else n_pass++;
  endtask

  task automatic test_wrap();
    jump = 1; jump_target = 32'hFFFF_FFFC;
    step(); idle();
    n_total++; if (pc_plus_inc !== 32'h0) $display("FAIL wrap_pc_plus_inc got %h want 0", pc_plus_inc); else n_pass++;
    step();
    n_total++; if (pc !== 32'h0) $display("FAIL wrap_pc got %h want 0", pc); else n_pass++;
  endtask

  task automatic test_reset_during_stall();
    jump = 1; jump_target = 32'h340; step(); idle();
    stall = 1; branch_taken = 1; branch_target = 32'h80;
    step();
    n_total++; if (redirect_pending !== 1'b1) $display("FAIL rst_stall_pre got %b want 1", redirect_pending); else n_pass++;
    branch_taken = 0; reset = 1;
    step(); idle();
    n_total++; if (pc !== 32'h0 || redirect_pending !== 1'b0)
      $display("FAIL rst_stall got pc=%h pend=%b want pc=0 pend=0", pc, redirect_pending); else n_pass++;
  endtask

  task automatic test_misalign();
    logic [W-1:0] exp_pc;
    logic         exp_mis;
`ifdef PC_ALIGN_CHECK_EN
    exp_pc = EXC; exp_mis = 1'b1;
`else
    exp_pc = 32'h402; exp_mis = 1'b0;
`endif
    jump = 1; jump_target = 32'h402;
    step(); idle();
    n_total++; if (pc !== exp_pc || misalign !== exp_mis)
      $display("FAIL misalign_load got pc=%h mis=%b want pc=%h mis=%b", pc, misalign, exp_pc, exp_mis); else n_pass++;
    step();
    n_total++; if (misalign !== 1'b0) $display("FAIL misalign_pulse got %b want 0", misalign); else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] t;
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(99) < 2);
      stall        = ($urandom_range(99) < 35);
      exc          = ($urandom_range(99) < 5);
      jr           = ($urandom_range(99) < 15);
      jump         = ($urandom_range(99) < 15);
      branch_taken = ($urandom_range(99) < 25);
      t = $urandom(); if ($urandom_range(9) != 0) t[1:0] = 2'b00; jr_target = t;
      t = $urandom(); if ($urandom_range(9) != 0) t[1:0] = 2'b00; jump_target = t;
      t = $urandom(); if ($urandom_range(9) != 0) t[1:0] = 2'b00; branch_target = t;
      step();
      n_total++; if (pc !== m_pc) $display("FAIL rand_pc[%0d] got %h want %h", i, pc, m_pc); else n_pass++;
      n_total++; if (pc_plus_inc !== m_pc + 32'd4) $display("FAIL rand_inc[%0d] got %h want %h", i, pc_plus_inc, m_pc + 32'd4); else n_pass++;
      n_total++; if (redirect_pending !== m_pv) $display("FAIL rand_pend[%0d] got %b want %b", i, redirect_pending, m_pv); else n_pass++;
      n_total++; if (misalign !== m_mis) $display("FAIL rand_mis[%0d] got %b want %b", i, misalign, m_mis); else n_pass++;
    end
    idle();
  endtask

  initial begin
    idle();
    m_pc = '0; m_pv = 0; m_pp = 0; m_pt = '0; m_mis = 0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_priority();
    test_stall_pending();
    test_exc_during_stall();
    test_wrap();
    test_reset_during_stall();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
